// File: rtl/coord_packetizer.sv
// coord_packetizer: serializes an (x,y,z) triple into a 9-byte sync/seq/data/xor-checksum frame
module coord_packetizer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      state_q;
  logic [7:0]  seq_q;
  logic [7:0]  chk_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] z_q;
  logic [7:0]  nxt_byte;
  assign idx_d = idx_q + 4'd1;
  // byte that follows the one currently presented
  always_comb begin
    nxt_byte = idx_d == 4'd1 ? seq_q :
               idx_d == 4'd2 ? x_q[15:8] :
               idx_d == 4'd3 ? x_q[7:0] :
               idx_d == 4'd4 ? y_q[15:8] :
               idx_d == 4'd5 ? y_q[7:0] :
               idx_d == 4'd6 ? z_q[15:8] :
               idx_d == 4'd7 ? z_q[7:0] : chk_q;
  end
  // frame FSM: latch triple and checksum on accept, step through bytes on each link handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seq_q      <= 8'd0;
      chk_q      <= 8'd0;
      tx_byte_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      idx_q      <= 4'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      z_q        <= 16'd0;
    end else if (state_q == IDLE) begin
      if (data_in_valid) begin
        x_q        <= x_in;
        y_q        <= y_in;
        z_q        <= z_in;
        chk_q      <= seq_q ^ x_in[15:8] ^ x_in[7:0] ^ y_in[15:8] ^ y_in[7:0] ^ z_in[15:8] ^ z_in[7:0];
        tx_byte_q  <= SYNC_BYTE;
        tx_valid_q <= 1'b1;
        idx_q      <= 4'd0;
        state_q    <= SEND;
      end
    end else if (tx_ready) begin
      if (idx_q == 4'd8) begin
        seq_q      <= seq_q + 8'd1;
        tx_byte_q  <= 8'd0;
        tx_valid_q <= 1'b0;
        idx_q      <= 4'd0;
        state_q    <= IDLE;
      end else begin
        idx_q     <= idx_d;
        tx_byte_q <= nxt_byte;
      end
    end
  end
  assign data_in_ready = !reset && state_q == IDLE;
  assign tx_byte       = tx_byte_q;
  assign tx_valid      = tx_valid_q;
  assign tx_sof        = tx_valid_q && idx_q == 4'd0;
  assign tx_eof        = tx_valid_q && idx_q == 4'd8;
  assign busy          = state_q == SEND;
endmodule

// File: tb/tb_coord_packetizer.sv
// tb_coord_packetizer: randomized and directed checks against a queue-based frame model
module tb_coord_packetizer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_in = 16'd0;
  logic [15:0] y_in = 16'd0;
  logic [15:0] z_in = 16'd0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_sof;
  logic        tx_eof;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pos = 0;
  logic [7:0]  mseq = 8'd0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          sof_t[$];
  coord_packetizer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push_frame();
    logic [7:0] f[9];
    f = '{8'hA5, mseq, x_in[15:8], x_in[7:0], y_in[15:8], y_in[7:0], z_in[15:8], z_in[7:0], 8'h00};
    for (int i = 1; i < 8; i++) f[8] ^= f[i];
    for (int i = 0; i < 9; i++) exp_q.push_back(f[i]);
    pos = 0;
  endtask
  task automatic cycle();
    logic m_busy;
    #1;
    m_busy = exp_q.size() > 0;
    check("tx_valid", tx_valid, m_busy);
    check("busy", busy, m_busy);
    check("data_in_ready", data_in_ready, !reset && !m_busy);
    if (m_busy) begin
      check("tx_byte", tx_byte, exp_q[0]);
      check("tx_sof", tx_sof, pos == 0);
      check("tx_eof", tx_eof, pos == 8);
    end else begin
      check("tx_byte_idle", tx_byte, 0);
      check("tx_sof_idle", tx_sof, 0);
      check("tx_eof_idle", tx_eof, 0);
    end
    if (tx_valid && tx_sof) sof_t.push_back(cyc);
    if (!reset && tx_valid && tx_ready) got_q.push_back(tx_byte);
    if (reset) begin
      exp_q.delete();
      pos = 0;
      mseq = 8'd0;
    end else if (!m_busy && data_in_valid) begin
      push_frame();
    end else if (m_busy && tx_ready) begin
      void'(exp_q.pop_front());
      pos++;
      if (pos == 9) begin
        pos = 0;
        mseq++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check_frame(input string tag, input int base, input logic [7:0] s, input logic [7:0] c);
    logic [7:0] r[9];
    r = '{8'hA5, s, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, c};
    check({tag, "_len"}, got_q.size() >= base + 9, 1);
    if (got_q.size() >= base + 9)
      for (int i = 0; i < 9; i++) check(tag, got_q[base+i], r[i]);
  endtask
  task automatic run_to(input int p);
    for (int n = 0; n < 20 && pos < p; n++) cycle();
    check("reach_pos", pos, p);
  endtask
  initial begin
    @(posedge clk);
    #1;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h00FF;
    tx_ready = 1'b1;
    got_q.delete();
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    repeat (12) cycle();
    check_frame("frame0", 0, 8'h00, 8'hBF);
    got_q.delete();
    sof_t.delete();
    data_in_valid = 1'b1;
    repeat (21) cycle();
    data_in_valid = 1'b0;
    repeat (12) cycle();
    check_frame("frame1", 0, 8'h01, 8'hBE);
    check("sof_count", sof_t.size() >= 2, 1);
    if (sof_t.size() >= 2) check("sof_period", sof_t[1] - sof_t[0], 10);
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    run_to(3);
    check("stall_byte", tx_byte, 8'h34);
    tx_ready = 1'b0;
    repeat (5) cycle();
    tx_ready = 1'b1;
    repeat (12) cycle();
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    run_to(2);
    x_in = 16'h5555; y_in = 16'h6666; z_in = 16'h7777;
    data_in_valid = 1'b1;
    repeat (3) cycle();
    data_in_valid = 1'b0;
    repeat (14) cycle();
    x_in = 16'd0; y_in = 16'd0; z_in = 16'd0;
    data_in_valid = 1'b1;
    repeat (2570) cycle();
    data_in_valid = 1'b0;
    repeat (12) cycle();
    x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h00FF;
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    run_to(4);
    check("byte4", tx_byte, 8'hAB);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    got_q.delete();
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    repeat (12) cycle();
    check_frame("after_reset", 0, 8'h00, 8'hBF);
    for (int n = 0; n < 4000; n++) begin
      data_in_valid = $urandom_range(0, 2) != 0;
      tx_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 199) == 0;
      x_in = 16'($urandom);
      y_in = 16'($urandom);
      z_in = 16'($urandom);
      cycle();
    end
    reset = 1'b0;
    data_in_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (12) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
